// File: rtl/add8u_share_pkg.sv
// Shared widths, the S1 stage record and the round-robin pick used by add8u_share_arb.
package add8u_share_pkg;

    localparam int OP_W     = 8;
    localparam int RES_W    = 9;
    localparam int OPS_W    = 16;
    localparam int ERRSUM_W = 24;
    localparam int ERRMAX_W = 9;
    localparam int ID_MAXW  = 3;

    typedef struct packed {
        logic                valid;
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [ID_MAXW-1:0]  id;
    } s1_stage_t;

    // Returns {found, index}: first set bit of vld at or above ptr, wrapping modulo n.
    function automatic logic [ID_MAXW:0] rr_pick(input logic [7:0] vld,
                                                 input logic [ID_MAXW-1:0] ptr,
                                                 input int unsigned n);
        logic [ID_MAXW:0] res;
        logic [3:0]       idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (k < int'(n)) begin
                idx = 4'(ptr) + 4'(k);
                if (idx >= 4'(n)) begin
                    idx = idx - 4'(n);
                end else begin
                    idx = idx;
                end
                if (vld[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add8u_core.sv
// Lower-part-OR approximate 8-bit adder: bits [1:0] are ORed, the upper six
// bits add exactly with a carry guessed from A[1]&B[1].
module add8u_core
    import add8u_share_pkg::*;
(
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic [RES_W-1:0] O
);

    logic [6:0] hi_s;

    assign hi_s = {1'b0, A[7:2]} + {1'b0, B[7:2]} + {6'd0, A[1] & B[1]};
    assign O    = {hi_s, A[1:0] | B[1:0]};

endmodule

// File: rtl/add8u_share_arb.sv
// Round-robin share of one add8u_core across NREQ requesters, 2-stage pipeline.
// Define ADD8U_SHARE_ERRSTAT_EN to build the approximate-vs-exact error statistics.
module add8u_share_arb
    import add8u_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    input  logic                 stat_clr,
    output logic [OPS_W-1:0]     stat_ops,
    output logic [ERRSUM_W-1:0]  stat_err_sum,
    output logic [ERRMAX_W-1:0]  stat_err_max
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    s1_stage_t          s1_q, s1_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;

    logic               s2_adv_s, s1_adv_s, accept_s;
    logic [7:0]         vld8_s;
    logic [ID_MAXW:0]   pick_s;
    logic [ID_MAXW-1:0] win_s;
    logic [RES_W-1:0]   core_o_s;

    add8u_core u_core (
        .A (s1_q.a),
        .B (s1_q.b),
        .O (core_o_s)
    );

    assign s2_adv_s = !rsp_valid_q || rsp_ready;
    assign s1_adv_s = !s1_q.valid || s2_adv_s;

    // Arbitration, handshake and next state of pointer and both stages.
    always_comb begin
        vld8_s                 = 8'd0;
        vld8_s[NREQ-1:0]       = req_valid;
        pick_s                 = rr_pick(vld8_s, ID_MAXW'(ptr_q), NREQ);
        win_s                  = pick_s[ID_MAXW-1:0];
        accept_s               = pick_s[ID_MAXW] & s1_adv_s;
        req_ready              = '0;
        ptr_d                  = ptr_q;
        s1_d                   = s1_q;
        rsp_valid_d            = rsp_valid_q;
        rsp_sum_d              = rsp_sum_q;
        rsp_id_d               = rsp_id_q;
        if (accept_s) begin
            req_ready[win_s] = 1'b1;
            s1_d.valid       = 1'b1;
            s1_d.a           = req_a[8*win_s +: 8];
            s1_d.b           = req_b[8*win_s +: 8];
            s1_d.id          = win_s;
            ptr_d            = (win_s == ID_MAXW'(NREQ-1)) ? '0 : IDW'(win_s + 3'd1);
        end else if (s1_adv_s) begin
            s1_d.valid = 1'b0;
        end else begin
            s1_d = s1_q;
        end
        if (s2_adv_s) begin
            rsp_valid_d = s1_q.valid;
            rsp_sum_d   = core_o_s;
            rsp_id_d    = IDW'(s1_q.id);
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Pipeline and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

`ifdef ADD8U_SHARE_ERRSTAT_EN
    logic [OPS_W-1:0]    ops_q, ops_d;
    logic [ERRSUM_W-1:0] esum_q, esum_d;
    logic [ERRMAX_W-1:0] emax_q, emax_d;
    logic [RES_W-1:0]    exact_s, err_s;
    logic [ERRSUM_W:0]   esum_ext_s;

    // Error of the approximate sum against the exact one, accumulated with saturation.
    always_comb begin
        exact_s    = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        err_s      = (exact_s >= core_o_s) ? (exact_s - core_o_s) : (core_o_s - exact_s);
        esum_ext_s = {1'b0, esum_q} + (ERRSUM_W+1)'(err_s);
        ops_d      = ops_q;
        esum_d     = esum_q;
        emax_d     = emax_q;
        if (stat_clr) begin
            ops_d  = '0;
            esum_d = '0;
            emax_d = '0;
        end else if (s2_adv_s && s1_q.valid) begin
            ops_d  = (ops_q == '1) ? ops_q : ops_q + 16'd1;
            esum_d = esum_ext_s[ERRSUM_W] ? '1 : esum_ext_s[ERRSUM_W-1:0];
            emax_d = (err_s > emax_q) ? err_s : emax_q;
        end else begin
            ops_d = ops_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q  <= '0;
            esum_q <= '0;
            emax_q <= '0;
        end else begin
            ops_q  <= ops_d;
            esum_q <= esum_d;
            emax_q <= emax_d;
        end
    end

    assign stat_ops     = ops_q;
    assign stat_err_sum = esum_q;
    assign stat_err_max = emax_q;
`else
    logic unused_stat_clr_s;

    assign unused_stat_clr_s = stat_clr;
    assign stat_ops          = '0;
    assign stat_err_sum      = '0;
    assign stat_err_max      = '0;
`endif

endmodule

// File: tb/tb_add8u_share_arb.sv
// Scoreboard bench for add8u_share_arb: accepts push expected results, a monitor pops on each response.
module tb_add8u_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*8-1:0]  req_a, req_b;
    logic               rsp_valid, rsp_ready;
    logic [8:0]         rsp_sum;
    logic [IDW-1:0]     rsp_id;
    logic               stat_clr;
    logic [15:0]        stat_ops;
    logic [23:0]        stat_err_sum;
    logic [8:0]         stat_err_max;

    logic [7:0] a_v [NREQ];
    logic [7:0] b_v [NREQ];

    int n_cmp = 0, n_fail = 0, n_acc = 0, n_rsp = 0;
    int mdl_ptr = 0;
    int exp_sum_q[$];
    int exp_id_q[$];
    int acc_log[$];

    add8u_share_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .stat_clr(stat_clr), .stat_ops(stat_ops),
        .stat_err_sum(stat_err_sum), .stat_err_max(stat_err_max)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = a_v[i];
            req_b[8*i +: 8] = b_v[i];
        end
    end

    // Approximate adder reference: low two bits ORed, carry guessed from bit 1 of both operands.
    function automatic int model_core(input int a, input int b);
        int lo, c;
        lo = (a % 4) | (b % 4);
        c  = ((a / 2) % 2) & ((b / 2) % 2);
        return ((a / 4) + (b / 4) + c) * 4 + lo;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept recorder: checks the grant against a round-robin model and queues the expected result.
    always @(negedge clk) begin
        if (rst_n && (req_ready != '0)) begin
            int win;
            win = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(mdl_ptr + k) % NREQ]) win = (mdl_ptr + k) % NREQ;
            end
            if (win < 0) begin
                check("grant_without_request", 32'(req_ready), 32'd0);
            end else begin
                check("grant_onehot", 32'(req_ready), 32'(1) << win);
                exp_sum_q.push_back(model_core(int'(a_v[win]), int'(b_v[win])));
                exp_id_q.push_back(win);
                acc_log.push_back(win);
                n_acc++;
                mdl_ptr = (win + 1) % NREQ;
            end
        end
    end

    // Response monitor: every transferred result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_sum_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                check("rsp_sum", 32'(rsp_sum), 32'(exp_sum_q.pop_front()));
                check("rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_sum_q.delete();
        exp_id_q.delete();
        mdl_ptr   = 0;
        req_valid = '0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic check_stats(input string tag, input int ops, input int esum, input int emax);
        check({tag, "_ops"}, 32'(stat_ops), 32'(ops));
        check({tag, "_err_sum"}, 32'(stat_err_sum), 32'(esum));
        check({tag, "_err_max"}, 32'(stat_err_max), 32'(emax));
    endtask

    initial begin
        int base, rsp0, esum, emax, e, ex, ap;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; stat_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin a_v[i] = 8'd0; b_v[i] = 8'd0; end
        cycles(3);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check_stats("reset", 0, 0, 0);
        cycles(1);
        rst_n = 1'b1;

        // Single request, 10 + 20 -> 30, two-cycle latency.
        cycles(1);
        a_v[0] = 8'd10; b_v[0] = 8'd20; req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0001);
        cycles(1);
        req_valid = '0;
        @(negedge clk);
        check("single_lat1_valid", 32'(rsp_valid), 32'd0);
        cycles(1);
        @(negedge clk);
        check("single_lat2_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_sum", 32'(rsp_sum), 32'd30);
        cycles(3);

        // Fairness from a fresh pointer.
        do_reset();
        a_v[0] = 8'd1; b_v[0] = 8'd1; a_v[1] = 8'd2;   b_v[1] = 8'd2;
        a_v[2] = 8'd3; b_v[2] = 8'd2; a_v[3] = 8'd255; b_v[3] = 8'd255;
        base = acc_log.size(); rsp0 = n_rsp; rsp_ready = 1'b1;
        req_valid = 4'b1111;
        cycles(8);
        req_valid = '0;
        cycles(4);
        check("fair_accepts", 32'(acc_log.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < acc_log.size()) check("fair_order", 32'(acc_log[base + i]), 32'(i % 4));
        end
        check("fair_responses", 32'(n_rsp - rsp0), 32'd8);
        check("fair_drained", 32'(exp_sum_q.size()), 32'd0);

        // Backpressure: two accepts, then stall with a stable output.
        base = n_acc; rsp0 = n_rsp; rsp_ready = 1'b0; req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check("bp_ready_low", 32'(req_ready), 32'd0);
                check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                if (exp_sum_q.size() > 0) begin
                    check("bp_sum_stable", 32'(rsp_sum), 32'(exp_sum_q[0]));
                    check("bp_id_stable", 32'(rsp_id), 32'(exp_id_q[0]));
                end
            end
            cycles(1);
        end
        req_valid = '0;
        check("bp_accepts", 32'(n_acc - base), 32'd2);
        rsp_ready = 1'b1;
        cycles(5);
        check("bp_responses", 32'(n_rsp - rsp0), 32'd2);
        check("bp_drained", 32'(exp_sum_q.size()), 32'd0);

        // Reset with S1 and S2 both occupied.
        rsp_ready = 1'b0; a_v[2] = 8'd77; b_v[2] = 8'd66; req_valid = 4'b0100;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_sum_q.delete(); exp_id_q.delete(); mdl_ptr = 0; req_valid = '0;
        cycles(2);
        rst_n = 1'b1; rsp0 = n_rsp; rsp_ready = 1'b1;
        cycles(4);
        check("rst_no_stale_rsp", 32'(n_rsp - rsp0), 32'd0);
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_ptr_zero", 32'(req_ready), 32'b0001);
        cycles(1);
        req_valid = '0;
        cycles(4);

        // Statistics over 256 pairs on requester 1.
        stat_clr = 1'b1;
        cycles(1);
        stat_clr = 1'b0;
        @(negedge clk);
        check_stats("pre_clr", 0, 0, 0);
        cycles(1);
        esum = 0; emax = 0; base = n_acc;
        for (int i = 0; i < 256; i++) begin
            a_v[1] = 8'($urandom_range(0, 255));
            b_v[1] = 8'($urandom_range(0, 255));
            if (i == 0) begin a_v[1] = 8'd3; b_v[1] = 8'd2; end
            req_valid = 4'b0010;
            ex = int'(a_v[1]) + int'(b_v[1]);
            ap = model_core(int'(a_v[1]), int'(b_v[1]));
            e  = (ex > ap) ? ex - ap : ap - ex;
            esum += e;
            if (e > emax) emax = e;
            cycles(1);
        end
        req_valid = '0;
        cycles(4);
        check("stat_accepts", 32'(n_acc - base), 32'd256);
`ifdef ADD8U_SHARE_ERRSTAT_EN
        check_stats("stat_on", 256, esum, emax);
`else
        check_stats("stat_off", 0, 0, 0);
`endif
        stat_clr = 1'b1;
        cycles(1);
        stat_clr = 1'b0;
        @(negedge clk);
        check_stats("post_clr", 0, 0, 0);
        check("final_drained", 32'(exp_sum_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/add8u_share_arb.md
# add8u_share_arb

Round-robin arbiter and 2-stage pipeline that time-shares one 8-bit unsigned approximate adder core among NREQ requesters using valid/ready handshakes. It sits between requesting datapath blocks and a single adder instance, so one LUT-cheap approximate adder replaces NREQ copies. Each result returns tagged with the requester index. Optional run-time error statistics compare every approximate sum against the exact sum.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): requester-id width, derived; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*8  operand A, requester i at bits [8i+7:8i].
- req_b  in  NREQ*8  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_sum  out  9  add8u_core output {carry, sum}.
- rsp_id  out  IDW  requester index of the result.
- stat_clr  in  1  synchronous clear of statistics.
- stat_ops  out  16  operations counted, saturating.
- stat_err_sum  out  24  accumulated absolute error, saturating.
- stat_err_max  out  9  largest absolute error seen.

## Operation
- Stage 1 (S1) holds the operand register: s1_valid, s1_a, s1_b, s1_id. Stage 2 (S2) holds the result register: rsp_valid, rsp_sum, rsp_id. add8u_core is combinational between S1 and S2.
- s2_adv = !rsp_valid | rsp_ready. s1_adv = !s1_valid | s2_adv.
- Arbitration: search from pointer ptr upward, modulo NREQ. The first i with req_valid[i] wins. req_ready[winner] = s1_adv; all other req_ready bits are 0.
- req_ready may depend on req_valid. req_valid must never depend on req_ready.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - S1 loads {1, req_a[i], req_b[i], i}.
  - ptr <= (i+1) mod NREQ.
  - With no accept, ptr holds.
- When s1_adv is high and there is no accept, s1_valid <= 0.
- When s2_adv is high, S2 loads S1: rsp_valid <= s1_valid, plus rsp_sum and rsp_id from S1.
- Output stays stable while rsp_valid & !rsp_ready.
- Starvation bound: a requester holding req_valid is accepted within NREQ accepts.
- Operands are passed unmodified. rsp_sum is exactly add8u_core(s1_a, s1_b). The block performs no arithmetic correction.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0.
  - s1_valid=0, ptr=0.
  - All stat_* = 0.
- Latency: result appears 2 cycles after the accept edge, with rsp_valid high in cycle N+2 when accepted in cycle N.
- Throughput: 1 result per cycle while rsp_ready=1.
- Stall with rsp_ready=0: S1 still accepts one more operand, then all req_ready drop to 0 until rsp_ready returns.
- Simultaneous drain and fill of either stage in the same cycle is legal and loses nothing.
- Reset asserted mid-operation: in-flight operations are discarded, with no response issued. All registers return to reset values immediately.

## Configuration
- ADD8U_SHARE_ERRSTAT_EN defined:
  - On each S2 load with s1_valid=1, compute e = |(s1_a+s1_b) − add8u_core(s1_a,s1_b)| at 9 bits.
  - Update statistics in that same edge:
    - stat_ops += 1, saturating at 0xFFFF.
    - stat_err_sum += e, saturating at 0xFFFFFF.
    - stat_err_max = max(stat_err_max, e).
  - stat_clr=1 zeroes all three counters. It takes priority over a coincident update.
- Undefined: stat_* are constant 0, stat_clr is ignored, and no exact adder is synthesized.

## Structure
- Package add8u_share_pkg holds:
  - the operand/result widths (8, 9);
  - the statistics widths (16, 24, 9);
  - the S1 stage struct typedef {valid, a, b, id}.
- One sub-module, add8u_core: a combinational wrapper exposing A[7:0], B[7:0], O[8:0] around the selected approximate adder. It is instantiated exactly once.
- The round-robin pick is a function in the package, not a module.

## Test plan
- Single request: after reset, req0 drives A=10, B=20 with rsp_ready=1. Expect req_ready[0] high in the same cycle, then rsp_valid 2 cycles later with rsp_id=0 and rsp_sum=add8u_core(10,20).
- Fairness: all 4 req_valid held high for 8 cycles. Expect accepted ids 0,1,2,3,0,1,2,3, one per cycle, and 8 responses in that order.
- Backpressure: continuous requests with rsp_ready=0 for 5 cycles. Expect exactly 2 accepts, then req_ready all 0, outputs stable throughout. Releasing rsp_ready delivers both results with no loss or duplication.
- Reset mid-flight: assert rst_n=0 while S1 and S2 are both valid. Expect rsp_valid=0 and ptr=0 immediately, and no stale response after release.
- Statistics (macro on): 256 random operand pairs. Expect stat_ops=256, and stat_err_sum and stat_err_max to match the model's Σ and max of |A+B − core(A,B)|. Then stat_clr=1 for one cycle gives all three counters 0.
- Statistics (macro off): identical traffic. Expect stat_ops, stat_err_sum and stat_err_max to stay 0.
